wb_arbiter: RTL and testbench

WB_ARBITER -- requirements
Module: wb_arbiter

---
 rtl/wb_arb_pkg.sv | 18 +
 rtl/rr_pick.sv | 32 +++
 rtl/wb_arbiter.sv | 118 +++++++++++
 tb/tb_wb_arbiter.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_arb_pkg.sv
// Shared defaults and requester identities for the writeback arbiter.
package wb_arb_pkg;

  localparam int unsigned NREQ_DEF    = 3;
  localparam int unsigned ADDR_W_DEF  = 5;
  localparam int unsigned SDATA_W_DEF = 16;
  localparam int unsigned VDATA_W_DEF = 128;
  localparam int unsigned CNT_W       = 16;

  localparam logic [CNT_W-1:0] CONFLICT_MAX = 16'hFFFF;

  typedef enum logic [1:0] {
    REQ_ALU = 2'd0,
    REQ_MEM = 2'd1,
    REQ_VEC = 2'd2
  } req_idx_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first valid requester at or above ptr, wrapping.
module rr_pick
  import wb_arb_pkg::*;
#(
  parameter int unsigned NREQ  = NREQ_DEF,
  parameter int unsigned IDX_W = 2
) (
  input  logic [NREQ-1:0]  valid,
  input  logic [IDX_W-1:0] ptr,
  output logic [NREQ-1:0]  grant_c,
  output logic [IDX_W-1:0] idx_c,
  output logic             any_c
);

  int unsigned cand;

  always_comb begin
    grant_c = '0;
    idx_c   = '0;
    any_c   = 1'b0;
    cand    = 0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      cand = (32'(ptr) + i) % NREQ;
      if (!any_c && valid[cand]) begin
        any_c         = 1'b1;
        grant_c[cand] = 1'b1;
        idx_c         = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// Round-robin writeback arbiter feeding scalar and vector register files
// through a single registered write port.
module wb_arbiter
  import wb_arb_pkg::*;
#(
  parameter int unsigned NREQ    = NREQ_DEF,
  parameter int unsigned ADDR_W  = ADDR_W_DEF,
  parameter int unsigned SDATA_W = SDATA_W_DEF,
  parameter int unsigned VDATA_W = VDATA_W_DEF
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NREQ-1:0]         req_valid,
  output logic [NREQ-1:0]         req_ready,
  input  logic [NREQ-1:0]         req_is_vec,
  input  logic [NREQ*ADDR_W-1:0]  req_addr,
  input  logic [NREQ*VDATA_W-1:0] req_data,
  input  logic                    stall,
  input  logic                    flush,
  output logic                    wre_scalar,
  output logic                    wre_vector,
  output logic [ADDR_W-1:0]       a3,
  output logic [SDATA_W-1:0]      wd3_scalar,
  output logic [VDATA_W-1:0]      wd3_vector,
  output logic [CNT_W-1:0]        conflict_cnt
);

  localparam int unsigned IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0]    pick_valid;
  logic [NREQ-1:0]    pick_grant;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_any;
  logic [VDATA_W-1:0] sel_data;

  logic [IDX_W-1:0]   rr_ptr_q,       rr_ptr_d;
  logic               wre_scalar_q,   wre_scalar_d;
  logic               wre_vector_q,   wre_vector_d;
  logic [ADDR_W-1:0]  a3_q,           a3_d;
  logic [SDATA_W-1:0] wd3_scalar_q,   wd3_scalar_d;
  logic [VDATA_W-1:0] wd3_vector_q,   wd3_vector_d;
  logic [CNT_W-1:0]   conflict_cnt_q, conflict_cnt_d;

  // Reset, stall and flush all hide every request from the picker.
  assign pick_valid = (reset || stall || flush) ? '0 : req_valid;

  rr_pick #(
    .NREQ  (NREQ),
    .IDX_W (IDX_W)
  ) u_rr_pick (
    .valid   (pick_valid),
    .ptr     (rr_ptr_q),
    .grant_c (pick_grant),
    .idx_c   (pick_idx),
    .any_c   (pick_any)
  );

  assign req_ready = pick_grant;
  assign sel_data  = req_data[32'(pick_idx)*VDATA_W +: VDATA_W];

  always_comb begin
    rr_ptr_d       = rr_ptr_q;
    wre_scalar_d   = 1'b0;
    wre_vector_d   = 1'b0;
    a3_d           = a3_q;
    wd3_scalar_d   = wd3_scalar_q;
    wd3_vector_d   = wd3_vector_q;
    conflict_cnt_d = conflict_cnt_q;

    if (flush) begin
      rr_ptr_d = '0;
    end else if (pick_any) begin
      rr_ptr_d = (32'(pick_idx) == NREQ - 1) ? '0 : pick_idx + IDX_W'(1);
    end

    // Address and data hold their last value whenever nothing transfers.
    if (pick_any) begin
      wre_scalar_d = ~req_is_vec[pick_idx];
      wre_vector_d = req_is_vec[pick_idx];
      a3_d         = req_addr[32'(pick_idx)*ADDR_W +: ADDR_W];
      wd3_scalar_d = sel_data[SDATA_W-1:0];
      wd3_vector_d = sel_data;
    end

    if (($countones(req_valid) > 1) && !stall && !flush &&
        (conflict_cnt_q != CONFLICT_MAX)) begin
      conflict_cnt_d = conflict_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr_q       <= '0;
      wre_scalar_q   <= 1'b0;
      wre_vector_q   <= 1'b0;
      a3_q           <= '0;
      wd3_scalar_q   <= '0;
      wd3_vector_q   <= '0;
      conflict_cnt_q <= '0;
    end else begin
      rr_ptr_q       <= rr_ptr_d;
      wre_scalar_q   <= wre_scalar_d;
      wre_vector_q   <= wre_vector_d;
      a3_q           <= a3_d;
      wd3_scalar_q   <= wd3_scalar_d;
      wd3_vector_q   <= wd3_vector_d;
      conflict_cnt_q <= conflict_cnt_d;
    end
  end

  assign wre_scalar   = wre_scalar_q;
  assign wre_vector   = wre_vector_q;
  assign a3           = a3_q;
  assign wd3_scalar   = wd3_scalar_q;
  assign wd3_vector   = wd3_vector_q;
  assign conflict_cnt = conflict_cnt_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against a behavioural model.
module tb_wb_arbiter;

  localparam int N  = 3;
  localparam int AW = 5;
  localparam int SW = 16;
  localparam int VW = 128;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N-1:0]    req_is_vec;
  logic [N*AW-1:0] req_addr;
  logic [N*VW-1:0] req_data;
  logic            stall;
  logic            flush;
  logic            wre_scalar;
  logic            wre_vector;
  logic [AW-1:0]   a3;
  logic [SW-1:0]   wd3_scalar;
  logic [VW-1:0]   wd3_vector;
  logic [15:0]     conflict_cnt;

  wb_arbiter dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_is_vec   (req_is_vec),
    .req_addr     (req_addr),
    .req_data     (req_data),
    .stall        (stall),
    .flush        (flush),
    .wre_scalar   (wre_scalar),
    .wre_vector   (wre_vector),
    .a3           (a3),
    .wd3_scalar   (wd3_scalar),
    .wd3_vector   (wd3_vector),
    .conflict_cnt (conflict_cnt)
  );

  always #5 clk = ~clk;

  // Requester-side state: each requester holds its request until granted.
  logic          v   [N];
  logic          isv [N];
  logic [AW-1:0] ad  [N];
  logic [VW-1:0] dt  [N];

  // Behavioural model of the arbiter's visible state.
  int          m_ptr;
  int          m_cnt;
  logic        m_wre_s, m_wre_v;
  logic [AW-1:0] m_a3;
  logic [VW-1:0] m_wd;
  int          last_g;
  logic [N-1:0] last_ready;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive();
    for (int k = 0; k < N; k++) begin
      req_valid[k]             = v[k];
      req_is_vec[k]            = isv[k];
      req_addr[k*AW +: AW]     = ad[k];
      req_data[k*VW +: VW]     = dt[k];
    end
  endtask

  task automatic model_reset();
    m_ptr = 0; m_cnt = 0; m_wre_s = 1'b0; m_wre_v = 1'b0; m_a3 = '0; m_wd = '0;
  endtask

  task automatic clear_reqs();
    for (int k = 0; k < N; k++) begin
      v[k] = 1'b0; isv[k] = 1'b0; ad[k] = '0; dt[k] = '0;
    end
  endtask

  task automatic check_outputs();
    check("wre_scalar", VW'(wre_scalar), VW'(m_wre_s));
    check("wre_vector", VW'(wre_vector), VW'(m_wre_v));
    check("a3", VW'(a3), VW'(m_a3));
    check("wd3_scalar", VW'(wd3_scalar), VW'(m_wd[SW-1:0]));
    check("wd3_vector", wd3_vector, m_wd);
    check("conflict_cnt", VW'(conflict_cnt), VW'(m_cnt));
  endtask

  // One clock cycle: called just after a falling edge with v/stall/flush set.
  task automatic step();
    int g;
    int nv;
    logic [N-1:0] exp_ready;
    drive();
    #1;
    g = -1;
    if (!stall && !flush) begin
      for (int i = 0; i < N; i++) begin
        int k;
        k = (m_ptr + i) % N;
        if (g < 0 && v[k]) g = k;
      end
    end
    exp_ready = (g >= 0) ? N'(1 << g) : '0;
    last_ready = req_ready;
    check("req_ready", VW'(req_ready), VW'(exp_ready));
    last_g = g;
    nv = 0;
    for (int k = 0; k < N; k++) nv += int'(v[k]);
    @(posedge clk);
    #1;
    if (nv >= 2 && !stall && !flush && m_cnt < 65535) m_cnt++;
    if (flush) m_ptr = 0;
    else if (g >= 0) m_ptr = (g + 1) % N;
    m_wre_s = (g >= 0) && !isv[g];
    m_wre_v = (g >= 0) && isv[g];
    if (g >= 0) begin
      m_a3 = ad[g];
      m_wd = dt[g];
      v[g] = 1'b0;
    end
    check_outputs();
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    stall = 1'b0;
    flush = 1'b0;
    clear_reqs();
    drive();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  int grants [3];

  initial begin
    reset = 1'b1; stall = 1'b0; flush = 1'b0;
    req_valid = '0; req_is_vec = '0; req_addr = '0; req_data = '0;
    last_g = -1; last_ready = '0;
    @(negedge clk);
    do_reset();
    check("reset_wre_scalar", VW'(wre_scalar), '0);
    check("reset_cnt", VW'(conflict_cnt), '0);
    check("reset_a3", VW'(a3), '0);

    // ALU scalar write
    v[0] = 1'b1; ad[0] = 5'd1; dt[0] = 128'h1; isv[0] = 1'b0;
    step();
    check("alu_ready", VW'(last_ready), VW'(3'b001));
    check("alu_wre_scalar", VW'(wre_scalar), VW'(1'b1));
    check("alu_a3", VW'(a3), VW'(5'd1));
    check("alu_wd3_scalar", VW'(wd3_scalar), VW'(16'h0001));
    check("alu_wre_vector", VW'(wre_vector), '0);
    step();
    check("alu_wre_one_cycle", VW'(wre_scalar), '0);

    // All three contend from reset
    do_reset();
    for (int k = 0; k < N; k++) begin
      v[k] = 1'b1; ad[k] = AW'(k + 10); dt[k] = VW'(k + 100); isv[k] = 1'b0;
    end
    for (int c = 0; c < 3; c++) begin
      step();
      grants[c] = last_g;
      check("rr_wre_b2b", VW'(wre_scalar), VW'(1'b1));
    end
    check("rr_grant0", VW'(grants[0]), VW'(0));
    check("rr_grant1", VW'(grants[1]), VW'(1));
    check("rr_grant2", VW'(grants[2]), VW'(2));
    check("rr_conflict_cnt", VW'(conflict_cnt), VW'(16'd2));

    // VEC vector write
    v[2] = 1'b1; ad[2] = 5'd3; isv[2] = 1'b1;
    dt[2] = 128'hDEAD_0123_4567_89AB_CDEF_0011_2233_BEEF;
    step();
    check("vec_wre_vector", VW'(wre_vector), VW'(1'b1));
    check("vec_wre_scalar", VW'(wre_scalar), '0);
    check("vec_a3", VW'(a3), VW'(5'd3));
    check("vec_wd3_vector", wd3_vector, 128'hDEAD_0123_4567_89AB_CDEF_0011_2233_BEEF);

    // MEM grant, then flush with ALU+VEC pending
    v[1] = 1'b1; ad[1] = 5'd7; dt[1] = 128'h77; isv[1] = 1'b0;
    step();
    check("mem_grant", VW'(last_ready), VW'(3'b010));
    v[0] = 1'b1; ad[0] = 5'd4; dt[0] = 128'h44; isv[0] = 1'b0;
    v[2] = 1'b1; ad[2] = 5'd5; dt[2] = 128'h55; isv[2] = 1'b1;
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("flush_no_grant", VW'(last_ready), '0);
    check("flush_wre_scalar", VW'(wre_scalar), '0);
    check("flush_wre_vector", VW'(wre_vector), '0);
    step();
    check("after_flush_alu", VW'(last_ready), VW'(3'b001));
    step();
    check("after_flush_vec", VW'(last_ready), VW'(3'b100));

    // Stall for four cycles with ALU pending (pointer sits at 0)
    v[0] = 1'b1; ad[0] = 5'd9; dt[0] = 128'h99; isv[0] = 1'b0;
    stall = 1'b1;
    for (int c = 0; c < 4; c++) begin
      step();
      check("stall_no_ready", VW'(last_ready), '0);
      check("stall_a3_hold", VW'(a3), VW'(5'd5));
    end
    stall = 1'b0;
    step();
    check("unstall_grant", VW'(last_ready), VW'(3'b001));
    check("unstall_a3", VW'(a3), VW'(5'd9));

    // Reset asserted while a write is on the port
    v[1] = 1'b1; ad[1] = 5'd12; dt[1] = 128'hABC; isv[1] = 1'b1;
    v[2] = 1'b1; ad[2] = 5'd13; dt[2] = 128'hDEF; isv[2] = 1'b0;
    step();
    check("pre_reset_wre_vector", VW'(wre_vector), VW'(1'b1));
    reset = 1'b1;
    #1;
    check("async_reset_wre_vector", VW'(wre_vector), '0);
    check("async_reset_wre_scalar", VW'(wre_scalar), '0);
    check("async_reset_cnt", VW'(conflict_cnt), '0);
    check("async_reset_ready", VW'(req_ready), '0);
    @(negedge clk);
    do_reset();

    // Randomized traffic
    for (int c = 0; c < 600; c++) begin
      for (int k = 0; k < N; k++) begin
        if (!v[k] && ($urandom_range(0, 2) != 0)) begin
          v[k]   = 1'b1;
          isv[k] = 1'($urandom_range(0, 1));
          ad[k]  = AW'($urandom);
          dt[k]  = {$urandom, $urandom, $urandom, $urandom};
        end
      end
      stall = ($urandom_range(0, 7) == 0);
      flush = ($urandom_range(0, 11) == 0);
      step();
    end
    stall = 1'b0;
    flush = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
